// File: rtl/fctn_decoder_seq.sv
// Clocked one-hot function decoder with modelled relay settle time.
// A load latches the code, holds all op lines low for SETTLE_CYCLES edges, then drives the selected line gated by v.
module fctn_decoder_seq #(
    parameter int CODE_W        = 3,
    parameter int SETTLE_CYCLES = 2,
    localparam int OUT_W        = 2 ** CODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CODE_W-1:0] fctn_code,
    input  logic              v,
    output logic [OUT_W-1:0]  op_code,
    output logic [CODE_W-1:0] code_q,
    output logic              busy,
    output logic              ready,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (SETTLE_CYCLES + 1 <= 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    // Code 0 maps to the MSB, so the one-hot pattern is the MSB shifted right by the code.
    localparam logic [OUT_W-1:0] MSB_ONE = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CODE_W-1:0] code_n;
    logic [OUT_W-1:0]  op_n;
    logic              busy_n, ready_n;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] c);
        return MSB_ONE >> c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            code_q  <= '0;
            op_code <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            code_q  <= code_n;
            op_code <= op_n;
            busy    <= busy_n;
            ready   <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        op_n    = op_code;
        busy_n  = busy;
        ready_n = ready;
        if (load) begin
            // A load always breaks the current line first, even for the same code.
            code_n = fctn_code;
            if (SETTLE_CYCLES == 0) begin
                state_n = HOLD;
                op_n    = v ? onehot(fctn_code) : '0;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end else begin
                state_n = SETTLING;
                cnt_n   = CNT_W'(SETTLE_CYCLES);
                op_n    = '0;
                ready_n = 1'b0;
                busy_n  = 1'b1;
            end
        end else begin
            case (state)
                SETTLING: begin
                    if (cnt == CNT_W'(1)) begin
                        state_n = HOLD;
                        op_n    = v ? onehot(code_q) : '0;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                HOLD:    op_n = v ? onehot(code_q) : '0;
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/fctn_decoder_seq.md
Name: fctn_decoder_seq

Overview:
Parametrised, clocked successor to the relay ALU's 3-to-8 function decoder. It latches an N-bit function code on a load strobe and models relay actuation time. During that time all op lines are forced low (break-before-make). After a programmable settle count it drives one one-hot op line, gated by the V supply/enable. It sits between the instruction/control sequencer and the ALU operation-select lines, and reports when the selected op line is stable.

Parameters:
CODE_W, 3, width of the function code; output width is OUT_W = 2**CODE_W (CODE_W >= 1).
SETTLE_CYCLES, 2, number of extra clock cycles the op lines stay low after a load before asserting (>= 0).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  strobe; when sampled high, the decoder captures fctn_code and starts a settle sequence.
fctn_code  input  CODE_W  function code, sampled only on a load edge.
v  input  1  supply/enable; op lines are driven only while v is sampled high in HOLD.
op_code  output  OUT_W  registered one-hot op lines. Code k drives bit OUT_W-1-k (code 0 = MSB = ADD for CODE_W=3, code 7 = LSB = NULL).
code_q  output  CODE_W  currently latched code.
busy  output  1  high while in SETTLING.
ready  output  1  high while in HOLD (op lines settled).

Behaviour:
- Reset (async, immediate): state=IDLE, op_code=0, code_q=0, busy=0, ready=0, settle counter=0. Reset asserted mid-settle or in HOLD aborts immediately. After release, nothing happens until the next load.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, SETTLING, HOLD.
- Load edge (load sampled high, any state):
  - code_q <= fctn_code; op_code <= 0; ready <= 0.
  - If SETTLE_CYCLES=0: go directly to HOLD; op_code <= onehot(fctn_code) if v else 0; ready <= 1; busy <= 0.
  - Otherwise: state <= SETTLING, cnt <= SETTLE_CYCLES, busy <= 1.
- SETTLING, no load: v and fctn_code are ignored; op_code stays 0.
  - If cnt==1: state <= HOLD; op_code <= onehot(code_q) if v else 0; ready <= 1; busy <= 0.
  - Else: cnt <= cnt-1.
- Latency: op_code/ready become valid after SETTLE_CYCLES+1 rising edges, counting the load edge as edge 1.
- HOLD, no load: op_code <= v ? onehot(code_q) : 0 on every edge, so a v change shows one cycle later. ready stays 1 regardless of v. fctn_code changes are ignored.
- Load during SETTLING restarts the sequence with the new code (cnt reloaded). Load during HOLD drops op_code to 0 on that edge and re-settles. This applies even when the new code equals code_q, so the line pulses low.
- load held high continuously keeps re-latching, so the block never leaves SETTLING; this is allowed.
- Invariant: popcount(op_code) <= 1 at all times. op_code != 0 only when ready=1. busy and ready are never both high.
- Counter width: clog2(SETTLE_CYCLES+1), minimum 1 bit.

Test Plan:
1. Defaults, reset, then load with code=0 and v=1 at edge 1 -> op_code=0, busy=1 after edges 1-2. After edge 3: op_code=8'b1000_0000, ready=1, busy=0, code_q=0.
2. Sweep codes 0..7 with v=1, waiting for ready each time -> op_code = 8'h80, 40, 20, 10, 08, 04, 02, 01 respectively. Never more than one bit set; op_code=0 for 2 cycles after each load.
3. In HOLD with code=5 (op_code=8'h04), drive v=0 for 3 cycles then 1 -> op_code=0 one cycle after v falls, ready stays 1. op_code=8'h04 one cycle after v rises. Toggling fctn_code in HOLD has no effect.
4. Load code=3, then load code=6 at the next edge (mid-settle) -> op_code stays 0 and busy stays 1 until 3 edges after the second load, then op_code=8'h02. Code 3 is never asserted.
5. Assert reset asynchronously (between edges) during SETTLING and again during HOLD -> op_code=0, ready=0, busy=0, code_q=0 immediately, without waiting for a clock edge. A load after release settles normally.
6. Parameter variant CODE_W=2, SETTLE_CYCLES=0: load code=1 with v=1 -> op_code=4'b0100 and ready=1 after the load edge itself. busy never asserts.
